// File: rtl/ahblite_uart_tx.sv
// rtl/ahblite_uart_tx.sv - AHB-Lite slave with TX FIFO, baud divider and 8N1 UART transmitter
// Optional: define UART_TX_STALL_ON_FULL_EN to stall DATA writes on a full FIFO instead of dropping them.
module ahblite_uart_tx #(
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [15:0] BAUDDIV_RESET = 16'd433
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        TXD,
    output logic        IRQ
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_BAUD   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic          r_dp_valid;
    logic          r_dp_write;
    logic [1:0]    r_dp_addr;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [15:0]   r_bauddiv;
    logic          r_tx_en;
    logic          r_irq_en;
    logic          r_overflow;

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_shift;
    logic [15:0]   r_div;
    logic [15:0]   r_baud_cnt;
    logic [2:0]    r_bit_cnt;

    logic          w_ap_valid;
    logic          w_dp_done;
    logic          w_wr;
    logic          w_wr_data;
    logic          w_stall;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_baud_tick;
    logic          w_busy;
    logic [7:0]    w_count8;
    logic          w_unused;

    assign w_unused = &{1'b0, HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    assign w_ap_valid = HSEL & HTRANS[1] & HREADY;
    assign w_dp_done  = r_dp_valid & HREADYOUT;
    assign w_wr       = w_dp_done & r_dp_write;
    assign w_wr_data  = w_wr & (r_dp_addr == ADDR_DATA);

    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_busy   = (r_state != S_IDLE);
    assign w_count8 = 8'(r_count);

`ifdef UART_TX_STALL_ON_FULL_EN
    // Hold the DATA write in its data phase until the FSM frees a slot.
    assign w_stall = r_dp_valid & r_dp_write & (r_dp_addr == ADDR_DATA) & w_full;
`else
    assign w_stall = 1'b0;
`endif

    assign HREADYOUT = ~w_stall;
    assign HRESP     = 1'b0;
    assign w_push    = w_wr_data & ~w_full;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= 2'd0;
        end else if (w_ap_valid) begin
            r_dp_valid <= 1'b1;
            r_dp_write <= HWRITE;
            r_dp_addr  <= HADDR[3:2];
        end else if (HREADYOUT) begin
            r_dp_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= HWDATA[7:0];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_bauddiv  <= BAUDDIV_RESET;
            r_tx_en    <= 1'b1;
            r_irq_en   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr && r_dp_addr == ADDR_BAUD) begin
                r_bauddiv <= HWDATA[15:0];
            end
            if (w_wr && r_dp_addr == ADDR_CTRL) begin
                r_tx_en  <= HWDATA[0];
                r_irq_en <= HWDATA[1];
            end
            if (w_wr_data && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_wr && r_dp_addr == ADDR_STATUS && HWDATA[3]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (r_dp_valid && !r_dp_write) begin
            case (r_dp_addr)
                ADDR_STATUS: HRDATA = {16'd0, w_count8, 4'd0, r_overflow, w_empty, w_full, w_busy};
                ADDR_BAUD:   HRDATA = {16'd0, r_bauddiv};
                ADDR_CTRL:   HRDATA = {30'd0, r_irq_en, r_tx_en};
                default:     HRDATA = 32'd0;
            endcase
        end
    end

    assign w_baud_tick = (r_baud_cnt == r_div);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_tx_en && !w_empty) begin
                    w_state_next = S_START;
                    w_pop        = 1'b1;
                    w_load       = 1'b1;
                end
            end
            S_START: begin
                if (w_baud_tick) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_tick && r_bit_cnt == 3'd7) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Chain straight into the next START so frames abut without an idle bit.
                if (w_baud_tick) begin
                    if (r_tx_en && !w_empty) begin
                        w_state_next = S_START;
                        w_pop        = 1'b1;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_shift    <= 8'd0;
            r_div      <= 16'd0;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
        end else if (w_load) begin
            r_shift    <= r_mem[r_rd_ptr];
            r_div      <= r_bauddiv;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
        end else if (r_state != S_IDLE) begin
            if (w_baud_tick) begin
                r_baud_cnt <= 16'd0;
                if (r_state == S_DATA) begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        case (r_state)
            S_START: TXD = 1'b0;
            S_DATA:  TXD = r_shift[0];
            default: TXD = 1'b1;
        endcase
    end

    assign IRQ = r_irq_en & w_empty & (r_state == S_IDLE);

endmodule
